// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N producer streams and one consumer for stream_mux_rr.
// Both directions share one interface. The slave modport is the mux's view of it.
interface stream_mux_rr_if #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int SW = $clog2(N)
);
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output mode,
    output sel,
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_chan,
    input  out_valid
  );

  modport slave (
    input  mode,
    input  sel,
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_chan,
    output out_valid
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel stream mux with explicit-select or round-robin grant and a one-entry
// registered output stage that holds its word under backpressure.
module stream_mux_rr #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  stream_mux_rr_if.slave  bus
);

  localparam int NP = 2 ** SW;

  logic              load_en;
  logic              gvalid;
  logic              xfer;
  logic              sel_ok;
  logic [SW-1:0]     grant;
  logic [SW-1:0]     rr_grant;
  logic [SW-1:0]     rr_idx;
  logic              rr_found;
  logic [NP-1:0]     vld_pad;
  logic [W-1:0]      gdata;
  logic [N-1:0]      in_ready;

  logic [SW-1:0]     ptr_q,   ptr_d;
  logic [W-1:0]      data_q,  data_d;
  logic [SW-1:0]     chan_q,  chan_d;
  logic              valid_q, valid_d;

  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] v);
    if (v == SW'(N - 1)) return '0;
    else                 return v + 1'b1;
  endfunction

  // Padding to a power of two lets an out-of-range sel index safely read a zero.
  assign vld_pad = NP'(bus.in_valid);
  assign sel_ok  = ({1'b0, bus.sel} < (SW + 1)'(N));
  assign load_en = !valid_q || bus.out_ready;

  // Round-robin search: first valid channel strictly after ptr, wrapping at N-1.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = ptr_q;
    rr_idx   = ptr_q;
    for (int k = 0; k < N; k++) begin
      rr_idx = wrap_inc(rr_idx);
      if (!rr_found && vld_pad[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = rr_idx;
      end
    end
  end

  always_comb begin
    if (bus.mode) begin
      grant  = rr_grant;
      gvalid = rr_found;
    end else begin
      grant  = bus.sel;
      gvalid = sel_ok && vld_pad[bus.sel];
    end
  end

  assign xfer = !rst && load_en && gvalid;

  always_comb begin
    in_ready = '0;
    gdata    = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) begin
        in_ready[i] = xfer;
        gdata       = bus.in_data[i*W +: W];
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    if (xfer) begin
      ptr_d   = grant;
      data_d  = gdata;
      chan_d  = grant;
      valid_d = 1'b1;
    end else if (load_en) begin
      valid_d = 1'b0;
    end
  end

  // ptr resets to N-1 so the first round-robin search begins at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= SW'(N - 1);
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: vector table, hand sequences and random traffic
// against a transaction-level model (N=4), plus an out-of-range select case (N=3).
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.N(4), .W(4)) bus4 ();
  stream_mux_rr_if #(.N(3), .W(4)) bus3 ();

  stream_mux_rr #(.N(4), .W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  stream_mux_rr #(.N(3), .W(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the output register as seen by the consumer.
  logic       m_v;
  logic [3:0] m_d;
  int         m_c;
  int         m_ptr;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic [15:0] data;
    logic        rdy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [3:0]  e_od;
    logic [1:0]  e_oc;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_v = 1'b0; m_d = 4'h0; m_c = 0; m_ptr = 3;
  endtask

  // Which channel the spec's rules would grant now; -1 means none.
  function automatic int model_grant(input logic m, input logic [1:0] s,
                                     input logic [3:0] v, input logic r);
    if (m_v && !r) return -1;
    if (!m) return v[s] ? int'(s) : -1;
    for (int k = 1; k <= 4; k++) begin
      if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic tick(input logic m, input logic [1:0] s, input logic [3:0] v,
                      input logic [15:0] d, input logic r);
    int g;
    logic [3:0] er;
    @(negedge clk);
    bus4.mode = m; bus4.sel = s; bus4.in_valid = v; bus4.in_data = d; bus4.out_ready = r;
    #1;
    g  = model_grant(m, s, v, r);
    er = (g < 0) ? 4'b0000 : 4'(1 << g);
    chk("model_in_ready", 32'(bus4.in_ready), 32'(er));
    chk("model_out_valid", 32'(bus4.out_valid), 32'(m_v));
    chk("model_out_data", 32'(bus4.out_data), 32'(m_d));
    chk("model_out_chan", 32'(bus4.out_chan), 32'(m_c));
    if (g >= 0) begin
      m_v = 1'b1; m_d = d[g*4 +: 4]; m_c = g; m_ptr = g;
    end else if (!m_v || r) begin
      m_v = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   chan_seq [7];
    int   prev_chan;
    int   words;

    bus4.mode = 1'b0; bus4.sel = '0; bus4.in_valid = '0; bus4.in_data = '0; bus4.out_ready = 1'b1;
    bus3.mode = 1'b0; bus3.sel = '0; bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = 1'b1;
    model_reset();

    tbl[0]  = '{1'b0, 2'd2, 4'b0100, 16'h0A00, 1'b1, 4'b0100, 1'b0, 4'h0, 2'd0};
    tbl[1]  = '{1'b0, 2'd2, 4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd2};
    tbl[2]  = '{1'b0, 2'd0, 4'b1111, 16'h1111, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd2};
    tbl[3]  = '{1'b0, 2'd1, 4'b1111, 16'h2222, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd2};
    tbl[4]  = '{1'b0, 2'd3, 4'b1111, 16'h3333, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd2};
    tbl[5]  = '{1'b0, 2'd1, 4'b1111, 16'h5555, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd2};
    tbl[6]  = '{1'b0, 2'd1, 4'b1111, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'hA, 2'd2};
    tbl[7]  = '{1'b1, 2'd0, 4'b1111, 16'h4321, 1'b0, 4'b0000, 1'b1, 4'h2, 2'd1};
    tbl[8]  = '{1'b1, 2'd0, 4'b1001, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'h2, 2'd1};
    tbl[9]  = '{1'b1, 2'd0, 4'b1001, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h4, 2'd3};
    tbl[10] = '{1'b1, 2'd0, 4'b0010, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h1, 2'd0};
    tbl[11] = '{1'b1, 2'd0, 4'b0010, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    tbl[12] = '{1'b1, 2'd0, 4'b0000, 16'h4321, 1'b1, 4'b0000, 1'b1, 4'h2, 2'd1};
    tbl[13] = '{1'b1, 2'd0, 4'b0000, 16'h4321, 1'b1, 4'b0000, 1'b0, 4'h2, 2'd1};

    #1;
    chk("reset_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("reset_out_data", 32'(bus4.out_data), 32'd0);
    chk("reset_out_chan", 32'(bus4.out_chan), 32'd0);
    chk("reset3_out_valid", 32'(bus3.out_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].mode, tbl[i].sel, tbl[i].vld, tbl[i].data, tbl[i].rdy);
      chk($sformatf("vec%0d_in_ready", i), 32'(bus4.in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_out_valid", i), 32'(bus4.out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d_out_data", i), 32'(bus4.out_data), 32'(tbl[i].e_od));
      chk($sformatf("vec%0d_out_chan", i), 32'(bus4.out_chan), 32'(tbl[i].e_oc));
    end

    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
           16'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    // Load a word, then assert reset between edges while it is held.
    tick(1'b0, 2'd3, 4'b1000, 16'h9000, 1'b0);
    tick(1'b0, 2'd3, 4'b1000, 16'h9000, 1'b0);
    @(negedge clk);
    bus4.in_valid = 4'b1111; bus4.out_ready = 1'b1;
    chk("pre_reset_out_valid", 32'(bus4.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("async_reset_out_data", 32'(bus4.out_data), 32'd0);
    chk("async_reset_out_chan", 32'(bus4.out_chan), 32'd0);
    chk("async_reset_in_ready", 32'(bus4.in_ready), 32'd0);
    model_reset();
    @(negedge clk);
    bus4.in_valid = 4'b0000;
    rst = 1'b0;

    chan_seq = '{-1, 0, 1, 2, 3, 0, 1};
    for (int k = 0; k < 7; k++) begin
      tick(1'b1, 2'd0, 4'b1111, 16'h8765, 1'b1);
      if (k > 0) chk($sformatf("rr_rot%0d_chan", k), 32'(bus4.out_chan), 32'(chan_seq[k]));
    end

    prev_chan = int'(bus4.out_chan);
    words = 0;
    for (int k = 0; k < 16; k++) begin
      tick(1'b1, 2'd0, 4'b1111, 16'($urandom), 1'b1);
      if (bus4.out_valid && bus4.out_ready) words++;
      chk($sformatf("full_rate%0d_chan", k), 32'(bus4.out_chan), 32'((prev_chan + 1) % 4));
      prev_chan = int'(bus4.out_chan);
    end
    chk("full_rate_words", 32'(words), 32'd16);

    // N=3: sel=3 is out of range and must never grant.
    @(negedge clk);
    bus3.mode = 1'b0; bus3.sel = 2'd1; bus3.in_valid = 3'b111; bus3.in_data = 12'h654; bus3.out_ready = 1'b1;
    #1;
    chk("n3_sel1_in_ready", 32'(bus3.in_ready), 32'b010);
    @(negedge clk);
    bus3.sel = 2'd3; bus3.out_ready = 1'b0;
    #1;
    chk("n3_held_out_valid", 32'(bus3.out_valid), 32'd1);
    chk("n3_held_out_data", 32'(bus3.out_data), 32'h5);
    chk("n3_held_out_chan", 32'(bus3.out_chan), 32'd1);
    chk("n3_held_in_ready", 32'(bus3.in_ready), 32'd0);
    @(negedge clk);
    bus3.out_ready = 1'b1;
    #1;
    chk("n3_sel3_in_ready", 32'(bus3.in_ready), 32'd0);
    chk("n3_drain_out_valid", 32'(bus3.out_valid), 32'd1);
    @(negedge clk);
    #1;
    chk("n3_empty_out_valid", 32'(bus3.out_valid), 32'd0);
    chk("n3_empty_out_data", 32'(bus3.out_data), 32'h5);
    chk("n3_empty_in_ready", 32'(bus3.in_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes and a registered output stage. It is the next generation of the team's 4:1 combinational mux. It adds two selection modes: explicit select, and round-robin arbitration across requesting channels. It also adds a one-entry output register that holds data under backpressure. It sits between multiple producer streams and a single consumer.

## Interface
- N, default 4: number of input channels, minimum 2.
- W, default 4: data width per channel, minimum 1.
- SW, default $clog2(N): select and channel-ID width. Derived; do not override.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = explicit select, 1 = round-robin.
- sel  input  SW  channel index, used only when mode=0.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- out_data  output  W  registered data.
- out_chan  output  SW  registered index of the source channel for out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.

## Operation
- load_en = !out_valid || out_ready. The output register may accept a new word this cycle.
- Grant, combinational, evaluated every cycle:
  - mode=0: grant = sel, gvalid = (sel < N) && in_valid[sel]. A sel value ≥ N (N not a power of 2) grants nothing.
  - mode=1: search starts at index ptr+1, increments mod N, and stops at the first in_valid bit. gvalid = |in_valid.
- in_ready[i] = load_en && gvalid && (grant == i). At most one bit is set. in_ready depends combinationally on out_ready, in_valid, mode and sel.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. At the next edge:
  - out_data ← in_data[g].
  - out_chan ← g.
  - out_valid ← 1.
  - ptr ← g. ptr is updated on every transfer in both modes.
- When load_en && !gvalid: out_valid ← 0 at the next edge. out_data and out_chan keep their old values.
- When out_valid && !out_ready: out_data, out_chan, out_valid and ptr are all held. in_ready is all zero.
- A mode or sel change takes effect at the next grant evaluation. It never alters a word already held in the output register.
- Internal state: ptr, SW bits, range 0..N-1. The wrap from N-1 to 0 is explicit. ptr never holds a value ≥ N.

## Timing
- Reset (asynchronous assert, synchronous deassert at the board level):
  - out_valid = 0, out_data = 0, out_chan = 0.
  - ptr = N-1, so the first round-robin search starts at channel 0.
- Latency: an input accepted in cycle t appears on out_* in cycle t+1.
- Throughput: one word per cycle while out_ready is held at 1.
- Simultaneous drain and load: out_valid && out_ready && a transfer in the same cycle. The new word replaces the old one with no bubble.
- Reset asserted mid-operation clears out_valid immediately, without waiting for a clock edge. A held word is dropped, and no in_ready is asserted while rst=1.
- Round-robin fairness: with all channels valid continuously and out_ready=1, each channel is granted exactly once every N cycles.

## Test plan
- Reset and basic select, N=4, W=4:
  - Assert rst mid-cycle: out_valid=0, out_data=0 and out_chan=0 are seen before the next edge.
  - Release, then drive mode=0, sel=2, in_valid=4'b0100, in_data[11:8]=4'hA.
  - Next cycle: out_data=4'hA, out_chan=2, out_valid=1, in_ready=4'b0100 during the accept cycle.
- Backpressure:
  - Hold out_ready=0 with out_valid=1 for 5 cycles while changing sel and in_data.
  - Required: out_data and out_chan stay constant and in_ready=0 throughout.
  - Raise out_ready: the held word drains, and the next word loads in the same cycle.
- Round-robin rotation:
  - mode=1, in_valid=4'b1111, out_ready=1, from reset.
  - Required: out_chan sequence 0,1,2,3,0,1.
- Round-robin skip:
  - From ptr=1, drive in_valid=4'b1001. Required: channel 3 is granted, then channel 0.
  - Drive only in_valid[1]=1. Required: channel 1 is granted repeatedly.
- Out-of-range select, N=3 (SW=2):
  - mode=0, sel=3, all channels valid. Required: in_ready=0, and out_valid drops to 0 one cycle after the last word drains.
- Simultaneous events:
  - Toggle mode from 0 to 1 while a word is held. Required: the held word is unchanged, and the next grant follows round-robin from ptr.
  - Drain and load in the same cycle at full rate for 16 cycles. Required: 16 words are delivered with no bubbles.
